// File: rtl/mandel_pkg.sv
// Constants and state encoding shared by the pixel sequencer and the iteration core.
package mandel_pkg;
  localparam int H_RES   = 640;
  localparam int V_RES   = 480;
  localparam int ADDR_W  = 19;
  localparam int ITER_W  = 8;
  localparam int TIMEOUT = 1023;

  // Out-of-range coordinates that keep the core idle.
  localparam logic [9:0] X_PARK = 10'h3FF;
  localparam logic [8:0] Y_PARK = 9'h1FF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_WRITE = 2'd3
  } seq_state_e;
endpackage

// File: rtl/mandel_pixel_sequencer_if.sv
// Core-side coordinate/result handshake plus the frame-buffer write port.
interface mandel_pixel_sequencer_if #(
  parameter int ADDR_W = mandel_pkg::ADDR_W,
  parameter int ITER_W = mandel_pkg::ITER_W
);
  logic [9:0]        x;
  logic [8:0]        y;
  logic              calc_start;
  logic              calc_done;
  logic [ITER_W-1:0] calc_iter;
  logic              fb_we;
  logic              fb_ready;
  logic [ADDR_W-1:0] fb_addr;
  logic [ITER_W-1:0] fb_data;

  modport master (
    output x, y, calc_start, fb_we, fb_addr, fb_data,
    input  calc_done, calc_iter, fb_ready
  );

  modport slave (
    input  x, y, calc_start, fb_we, fb_addr, fb_data,
    output calc_done, calc_iter, fb_ready
  );
endinterface

// File: rtl/mandel_raster_counter.sv
// Column/row walker with a running linear address that always equals row*H_RES+col.
module mandel_raster_counter #(
  parameter int H_RES  = mandel_pkg::H_RES,
  parameter int V_RES  = mandel_pkg::V_RES,
  parameter int ADDR_W = mandel_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              advance,
  output logic [9:0]        col,
  output logic [8:0]        row,
  output logic [ADDR_W-1:0] addr,
  output logic              last_col,
  output logic              last_pixel
);
  logic [9:0]        col_q, col_d;
  logic [8:0]        row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  assign last_col   = (col_q == 10'(H_RES - 1));
  assign last_pixel = last_col && (row_q == 9'(V_RES - 1));

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    addr_d = addr_q;
    // Wrapping to zero after the last pixel keeps the address invariant between frames.
    if (clear || (advance && last_pixel)) begin
      col_d  = '0;
      row_d  = '0;
      addr_d = '0;
    end else if (advance) begin
      addr_d = addr_q + ADDR_W'(1);
      if (last_col) begin
        col_d = '0;
        row_d = row_q + 9'd1;
      end else begin
        col_d = col_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q  <= '0;
      row_q  <= '0;
      addr_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      addr_q <= addr_d;
    end
  end

  assign col  = col_q;
  assign row  = row_q;
  assign addr = addr_q;
endmodule

// File: rtl/mandel_pixel_sequencer.sv
// Raster walker for the Mandelbrot core: issues one coordinate, waits for the
// iteration count (or watchdog expiry) and writes it to the frame buffer.
module mandel_pixel_sequencer #(
  parameter int H_RES   = mandel_pkg::H_RES,
  parameter int V_RES   = mandel_pkg::V_RES,
  parameter int ADDR_W  = mandel_pkg::ADDR_W,
  parameter int ITER_W  = mandel_pkg::ITER_W,
  parameter int TIMEOUT = mandel_pkg::TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  mandel_pixel_sequencer_if.master bus,
  output logic busy,
  output logic frame_done,
  output logic timeout_err
);
  import mandel_pkg::*;

  localparam int WD_W = $clog2(TIMEOUT + 1);

  seq_state_e        state_q, state_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic [ITER_W-1:0] fb_data_q, fb_data_d;
  logic              timeout_err_q, timeout_err_d;
  logic              frame_done_q, frame_done_d;

  logic              cnt_clear, cnt_advance;
  logic [9:0]        col;
  logic [8:0]        row;
  logic [ADDR_W-1:0] addr;
  logic              last_col, last_pixel;

  mandel_raster_counter #(
    .H_RES  (H_RES),
    .V_RES  (V_RES),
    .ADDR_W (ADDR_W)
  ) u_raster (
    .clk        (clk),
    .reset      (reset),
    .clear      (cnt_clear),
    .advance    (cnt_advance),
    .col        (col),
    .row        (row),
    .addr       (addr),
    .last_col   (last_col),
    .last_pixel (last_pixel)
  );

  always_comb begin
    state_d       = state_q;
    wdog_d        = wdog_q;
    fb_data_d     = fb_data_q;
    timeout_err_d = timeout_err_q;
    frame_done_d  = 1'b0;
    cnt_clear     = 1'b0;
    cnt_advance   = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        cnt_clear     = 1'b1;
        timeout_err_d = 1'b0;
        state_d       = S_ISSUE;
      end
      S_ISSUE: begin
        wdog_d  = '0;
        state_d = S_WAIT;
      end
      // WAIT lasts at most TIMEOUT cycles; a real result wins over expiry.
      S_WAIT: begin
        if (bus.calc_done) begin
          fb_data_d = bus.calc_iter;
          state_d   = S_WRITE;
        end else if (wdog_q >= WD_W'(TIMEOUT - 1)) begin
          fb_data_d     = '1;
          timeout_err_d = 1'b1;
          state_d       = S_WRITE;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      S_WRITE: if (bus.fb_ready) begin
        cnt_advance = 1'b1;
        if (last_pixel) begin
          frame_done_d = 1'b1;
          state_d      = S_IDLE;
        end else begin
          state_d = S_ISSUE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      wdog_q        <= '0;
      fb_data_q     <= '0;
      timeout_err_q <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      wdog_q        <= wdog_d;
      fb_data_q     <= fb_data_d;
      timeout_err_q <= timeout_err_d;
      frame_done_q  <= frame_done_d;
    end
  end

  logic issuing;
  assign issuing        = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign bus.x          = issuing ? col : X_PARK;
  assign bus.y          = issuing ? row : Y_PARK;
  assign bus.calc_start = (state_q == S_ISSUE);
  assign bus.fb_we      = (state_q == S_WRITE);
  assign bus.fb_addr    = addr;
  assign bus.fb_data    = fb_data_q;
  assign busy           = (state_q != S_IDLE);
  assign frame_done     = frame_done_q;
  assign timeout_err    = timeout_err_q;
endmodule

// File: tb/tb_mandel_pixel_sequencer.sv
// Small-raster (4x3) bench: randomized core latency, iteration values and
// frame-buffer back-pressure, checked against an address-derived pixel model.
module tb_mandel_pixel_sequencer;
  localparam int H = 4, V = 3, NPIX = H * V, TO = 20;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic busy, frame_done, timeout_err;
  always #5 clk = ~clk;

  mandel_pixel_sequencer_if #(.ADDR_W(19), .ITER_W(8)) bus();

  mandel_pixel_sequencer #(
    .H_RES(H), .V_RES(V), .ADDR_W(19), .ITER_W(8), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus.master),
    .busy(busy), .frame_done(frame_done), .timeout_err(timeout_err)
  );

  typedef struct { int addr; int data; int cyc; } wr_t;
  typedef struct { int x; int y; int cyc; } cs_t;
  wr_t wr_q[$];
  cs_t cs_q[$];
  wr_t w;
  cs_t c;

  int n_cmp = 0, n_fail = 0, cyc = 0;
  int fd_cnt = 0, fd_cyc = 0, park_err = 0, stab_err = 0, stall_we = 0;
  int core_cnt = 0, core_lat = 5, stall_addr = -1, stall_left = 0, hang_x = -1, hang_y = -1;
  bit lat_rand = 0, rand_ready = 0, stray_on = 0;
  logic [7:0] salt = 8'd0, core_res = 8'd0;
  logic prev_hold = 1'b0;
  logic [18:0] prev_addr = '0;
  logic [7:0] prev_data = '0;

  always @(posedge clk) cyc++;

  // Core model, frame-buffer model and protocol logger, all driven away from the active edge.
  always @(negedge clk) begin
    bus.calc_done = 1'b0;
    if (reset) core_cnt = 0;
    else begin
      if (core_cnt > 0) begin
        core_cnt--;
        if (core_cnt == 0) begin bus.calc_done = 1'b1; bus.calc_iter = core_res; end
      end
      if (bus.calc_start) begin
        c.x = int'(bus.x); c.y = int'(bus.y); c.cyc = cyc;
        cs_q.push_back(c);
        if (!(c.x == hang_x && c.y == hang_y)) begin
          core_cnt = lat_rand ? int'($urandom_range(1, 6)) : core_lat;
          core_res = 8'(bus.x + 10'(bus.y)) + salt;
        end
      end
      if (stray_on && (!busy || bus.fb_we)) begin
        bus.calc_done = 1'b1;
        bus.calc_iter = 8'($urandom);
      end
    end
    if (bus.fb_we && int'(bus.fb_addr) == stall_addr && stall_left > 0) begin
      bus.fb_ready = 1'b0;
      stall_left--;
    end else bus.fb_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    if (!reset) begin
      if (bus.fb_we && bus.fb_ready) begin
        w.addr = int'(bus.fb_addr); w.data = int'(bus.fb_data); w.cyc = cyc;
        wr_q.push_back(w);
      end
      if (frame_done) begin fd_cnt++; fd_cyc = cyc; end
      if (bus.fb_we && int'(bus.fb_addr) == stall_addr) stall_we++;
      if ((bus.fb_we || !busy) && (bus.x !== 10'h3FF || bus.y !== 9'h1FF)) park_err++;
      if (bus.calc_start && bus.fb_we) park_err++;
      if (prev_hold && (!bus.fb_we || bus.fb_addr !== prev_addr || bus.fb_data !== prev_data)) stab_err++;
      prev_hold = bus.fb_we && !bus.fb_ready;
      prev_addr = bus.fb_addr;
      prev_data = bus.fb_data;
    end else prev_hold = 1'b0;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "global timeout");
  end

  function automatic int exp_data(int a, int hang);
    if (a == hang) return 255;
    return ((a % H) + (a / H) + int'(salt)) & 255;
  endfunction

  task automatic clear_logs();
    wr_q.delete(); cs_q.delete();
    fd_cnt = 0; park_err = 0; stab_err = 0; stall_we = 0;
  endtask

  task automatic run_frame(input bit spam, output bit ok);
    ok = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (frame_done) begin ok = 1'b1; break; end
      start = spam ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL frame_bound: no frame_done within 3000 cycles (writes=%0d)", wr_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.x, bus.y, bus.calc_start, bus.fb_we, busy, frame_done, timeout_err} !== {10'h3FF, 9'h1FF, 5'b0}) begin
      n_fail++;
      $display("FAIL reset_ctrl: x=%h y=%h cs=%b we=%b busy=%b fd=%b terr=%b, want 3ff/1ff/0...",
               bus.x, bus.y, bus.calc_start, bus.fb_we, busy, frame_done, timeout_err);
    end
    n_cmp++;
    if ({bus.fb_addr, bus.fb_data} !== 27'd0) begin
      n_fail++; $display("FAIL reset_fb: addr=%0d data=%h, want 0/0", bus.fb_addr, bus.fb_data);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || bus.calc_start !== 1'b0 || bus.x !== 10'h3FF || bus.fb_we !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_reset: busy=%b cs=%b x=%h we=%b", busy, bus.calc_start, bus.x, bus.fb_we);
    end
  endtask

  task automatic test_frame();
    bit ok;
    clear_logs(); salt = 8'($urandom); lat_rand = 1;
    run_frame(1'b0, ok);
    n_cmp++;
    if (wr_q.size() != NPIX) begin n_fail++; $display("FAIL frame_count: got %0d want %0d", wr_q.size(), NPIX); end
    for (int i = 0; i < NPIX && i < wr_q.size(); i++) begin
      n_cmp++;
      if (wr_q[i].addr != i || wr_q[i].data != exp_data(i, -1)) begin
        n_fail++; $display("FAIL frame_write[%0d]: addr=%0d data=%0d want %0d/%0d", i, wr_q[i].addr, wr_q[i].data, i, exp_data(i, -1));
      end
    end
    for (int i = 0; i < NPIX && i < cs_q.size(); i++) begin
      n_cmp++;
      if (cs_q[i].x != i % H || cs_q[i].y != i / H) begin
        n_fail++; $display("FAIL frame_coord[%0d]: x=%0d y=%0d want %0d/%0d", i, cs_q[i].x, cs_q[i].y, i % H, i / H);
      end
    end
    n_cmp++;
    if (fd_cnt != 1 || wr_q.size() != NPIX || fd_cyc != wr_q[NPIX-1].cyc + 1) begin
      n_fail++; $display("FAIL frame_done: count=%0d cyc=%0d, want 1 pulse right after last write", fd_cnt, fd_cyc);
    end
    n_cmp++;
    if (busy !== 1'b0 || timeout_err !== 1'b0 || park_err != 0) begin
      n_fail++; $display("FAIL frame_end: busy=%b terr=%b park_err=%0d, want 0/0/0", busy, timeout_err, park_err);
    end
  endtask

  task automatic test_stall();
    bit ok;
    int n5;
    clear_logs(); salt = 8'($urandom); lat_rand = 1;
    stall_addr = 5; stall_left = 7;
    run_frame(1'b0, ok);
    n_cmp++;
    if (wr_q.size() != NPIX) begin n_fail++; $display("FAIL stall_count: got %0d want %0d", wr_q.size(), NPIX); end
    n5 = 0;
    for (int i = 0; i < NPIX && i < wr_q.size(); i++) begin
      if (wr_q[i].addr == 5) n5++;
      n_cmp++;
      if (wr_q[i].addr != i || wr_q[i].data != exp_data(i, -1)) begin
        n_fail++; $display("FAIL stall_write[%0d]: addr=%0d data=%0d want %0d/%0d", i, wr_q[i].addr, wr_q[i].data, i, exp_data(i, -1));
      end
    end
    n_cmp++;
    if (n5 != 1 || stall_we != 8) begin
      n_fail++; $display("FAIL stall_hold: writes@5=%0d we_cycles=%0d, want 1/8", n5, stall_we);
    end
    n_cmp++;
    if (stab_err != 0 || park_err != 0) begin
      n_fail++; $display("FAIL stall_stable: stab_err=%0d park_err=%0d, want 0/0", stab_err, park_err);
    end
    stall_addr = -1;
  endtask

  task automatic test_timeout();
    bit ok;
    clear_logs(); salt = 8'($urandom); lat_rand = 0; core_lat = 5;
    hang_x = 2; hang_y = 0;
    run_frame(1'b0, ok);
    n_cmp++;
    if (wr_q.size() != NPIX) begin n_fail++; $display("FAIL to_count: got %0d want %0d", wr_q.size(), NPIX); end
    for (int i = 0; i < NPIX && i < wr_q.size(); i++) begin
      n_cmp++;
      if (wr_q[i].addr != i || wr_q[i].data != exp_data(i, 2)) begin
        n_fail++; $display("FAIL to_write[%0d]: addr=%0d data=%0d want %0d/%0d", i, wr_q[i].addr, wr_q[i].data, i, exp_data(i, 2));
      end
    end
    n_cmp++;
    if (wr_q.size() < 3 || cs_q.size() < 3 || wr_q[2].cyc - cs_q[2].cyc != TO + 1) begin
      n_fail++; $display("FAIL to_latency: got %0d want %0d cycles", (wr_q.size() > 2 && cs_q.size() > 2) ? wr_q[2].cyc - cs_q[2].cyc : -1, TO + 1);
    end
    n_cmp++;
    if (timeout_err !== 1'b1 || fd_cnt != 1) begin
      n_fail++; $display("FAIL to_sticky: terr=%b fd=%0d, want 1/1", timeout_err, fd_cnt);
    end
    hang_x = -1; hang_y = -1;
    clear_logs();
    run_frame(1'b0, ok);
    n_cmp++;
    if (timeout_err !== 1'b0 || wr_q.size() != NPIX) begin
      n_fail++; $display("FAIL to_clear: terr=%b writes=%0d, want 0/%0d", timeout_err, wr_q.size(), NPIX);
    end
  endtask

  task automatic test_stray();
    bit ok;
    clear_logs(); stray_on = 1;
    repeat (6) @(negedge clk);
    n_cmp++;
    if (cs_q.size() != 0 || wr_q.size() != 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL stray_idle: cs=%0d writes=%0d busy=%b, want 0/0/0", cs_q.size(), wr_q.size(), busy);
    end
    salt = 8'($urandom); lat_rand = 1; rand_ready = 1;
    stall_addr = 3; stall_left = 4;
    run_frame(1'b1, ok);
    stray_on = 0; rand_ready = 0; stall_addr = -1;
    n_cmp++;
    if (wr_q.size() != NPIX || cs_q.size() != NPIX || fd_cnt != 1) begin
      n_fail++; $display("FAIL stray_count: writes=%0d issues=%0d fd=%0d, want %0d/%0d/1", wr_q.size(), cs_q.size(), fd_cnt, NPIX, NPIX);
    end
    for (int i = 0; i < NPIX && i < wr_q.size(); i++) begin
      n_cmp++;
      if (wr_q[i].addr != i || wr_q[i].data != exp_data(i, -1)) begin
        n_fail++; $display("FAIL stray_write[%0d]: addr=%0d data=%0d want %0d/%0d", i, wr_q[i].addr, wr_q[i].data, i, exp_data(i, -1));
      end
    end
    n_cmp++;
    if (stab_err != 0 || park_err != 0) begin
      n_fail++; $display("FAIL stray_stable: stab_err=%0d park_err=%0d, want 0/0", stab_err, park_err);
    end
  endtask

  task automatic test_reset_mid();
    bit ok, seen;
    clear_logs(); salt = 8'($urandom); lat_rand = 0; core_lat = 5;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    seen = 0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (cs_q.size() >= 8) begin seen = 1; break; end
    end
    n_cmp++;
    if (!seen) begin n_fail++; $display("FAIL rst_mid_bound: pixel 7 never issued (issues=%0d)", cs_q.size()); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({bus.x, bus.y, bus.calc_start, bus.fb_we, busy, frame_done, timeout_err} !== {10'h3FF, 9'h1FF, 5'b0}) begin
      n_fail++; $display("FAIL rst_mid_ctrl: x=%h y=%h cs=%b we=%b busy=%b", bus.x, bus.y, bus.calc_start, bus.fb_we, busy);
    end
    n_cmp++;
    if ({bus.fb_addr, bus.fb_data} !== 27'd0 || wr_q.size() != 7) begin
      n_fail++; $display("FAIL rst_mid_fb: addr=%0d data=%h writes=%0d, want 0/0/7", bus.fb_addr, bus.fb_data, wr_q.size());
    end
    @(negedge clk); reset = 1'b0;
    repeat (2) @(negedge clk);
    clear_logs();
    run_frame(1'b0, ok);
    n_cmp++;
    if (wr_q.size() != NPIX) begin n_fail++; $display("FAIL rst_restart_count: got %0d want %0d", wr_q.size(), NPIX); end
    for (int i = 0; i < NPIX && i < wr_q.size(); i++) begin
      n_cmp++;
      if (wr_q[i].addr != i || wr_q[i].data != exp_data(i, -1)) begin
        n_fail++; $display("FAIL rst_restart[%0d]: addr=%0d data=%0d want %0d/%0d", i, wr_q[i].addr, wr_q[i].data, i, exp_data(i, -1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_frame();
    test_stall();
    test_timeout();
    test_stray();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
